// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants and types for the data-memory load/store sequencer
// Purpose: RV32I load/store funct3 codes, sequencer state encoding, default
//          byte-address width and the request legality helper.
// Ports:   none (package).
package dmem_pkg;

  // Byte-address width covered by the 64 x 32-bit data memory.
  localparam int DMEM_AW = 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_RDATA = 3'd2,
    ST_WR    = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Width/alignment legality of a request; the address range is checked
  // separately because it depends on the AW parameter of the instance.
  function automatic logic f3_align_bad(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = addr_lo[0];
      F3_W:    bad = (addr_lo != 2'b00);
      F3_BU:   bad = we;                     // no unsigned stores
      F3_HU:   bad = we | addr_lo[0];
      default: bad = 1'b1;                   // 011, 110, 111
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - core-side request/response bundle of the load/store sequencer
// Purpose: groups the memory-stage request handshake and the response pulse.
// Signals: Req_valid/Req_ready/Req_we/Req_funct3/Req_addr/Req_wdata (request),
//          Rsp_valid/Rsp_rdata/Rsp_err (response, single-cycle, no backpressure).
// Modports: master = core side, slave = controller side.
interface dmem_if;
  logic        Req_valid;
  logic        Req_ready;
  logic        Req_we;
  logic [2:0]  Req_funct3;
  logic [31:0] Req_addr;
  logic [31:0] Req_wdata;
  logic        Rsp_valid;
  logic [31:0] Rsp_rdata;
  logic        Rsp_err;

  modport master (
    output Req_valid, Req_we, Req_funct3, Req_addr, Req_wdata,
    input  Req_ready, Rsp_valid, Rsp_rdata, Rsp_err
  );

  modport slave (
    input  Req_valid, Req_we, Req_funct3, Req_addr, Req_wdata,
    output Req_ready, Rsp_valid, Rsp_rdata, Rsp_err
  );
endinterface

// File: rtl/dmem_lane.sv
// rtl/dmem_lane.sv - byte/halfword lane extract and merge for the load/store sequencer
// Purpose: purely combinational lane logic on one memory word.
// Ports:   word_i   - word read from memory
//          lane_i   - byte address bits [1:0]
//          funct3_i - RV32I load/store width code
//          sdata_i  - store data (low byte/half used for SB/SH)
//          load_o   - selected lane, sign- or zero-extended
//          merged_o - word_i with the store lane replaced by sdata_i
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] sdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (lane_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    // Halfwords are only ever legal at lane 0 or 2.
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    load_o = word_i;
    case (funct3_i)
      F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_o = {24'h000000, byte_sel};
      F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_o = {16'h0000, half_sel};
      default: load_o = word_i;
    endcase
  end

  always_comb begin
    merged_o = word_i;
    case (funct3_i)
      F3_B: begin
        case (lane_i)
          2'd0: merged_o[7:0]   = sdata_i[7:0];
          2'd1: merged_o[15:8]  = sdata_i[7:0];
          2'd2: merged_o[23:16] = sdata_i[7:0];
          2'd3: merged_o[31:24] = sdata_i[7:0];
          default: merged_o = word_i;
        endcase
      end
      F3_H: begin
        if (lane_i[1]) merged_o[31:16] = sdata_i[15:0];
        else           merged_o[15:0]  = sdata_i[15:0];
      end
      default: merged_o = sdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - RV32I load/store sequencer for a word-only single-port data memory
// Purpose: accepts one core request at a time, rejects illegal ones, performs
//          word reads, extended sub-word loads, word writes and sub-word
//          read-modify-write stores, then issues a one-cycle response.
// Ports:   Clk, Rst_n (asynchronous, active-low)
//          bus       - dmem_if.slave request/response bundle
//          Mem_addr  - latched word address (0 in IDLE)
//          Mem_rd_en - read strobe, data on Mem_rdata next cycle
//          Mem_rdata - memory read data
//          Mem_wr_en - word write strobe
//          Mem_wdata - word write data
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int AW = DMEM_AW
) (
  input  logic        Clk,
  input  logic        Rst_n,
  dmem_if.slave       bus,
  output logic [31:0] Mem_addr,
  output logic        Mem_rd_en,
  input  logic [31:0] Mem_rdata,
  output logic        Mem_wr_en,
  output logic [31:0] Mem_wdata
);

  state_e      state_q, state_d;
  logic [31:0] addr_q,  addr_d;
  logic [2:0]  f3_q,    f3_d;
  logic        we_q,    we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] wbuf_q,  wbuf_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q,   err_d;

  logic [31:0] lane_load;
  logic [31:0] lane_merged;
  logic        req_err;

  dmem_lane u_lane (
    .word_i   (Mem_rdata),
    .lane_i   (addr_q[1:0]),
    .funct3_i (f3_q),
    .sdata_i  (wdata_q),
    .load_o   (lane_load),
    .merged_o (lane_merged)
  );

  // Any address bit at or above AW lies outside the memory.
  assign req_err = f3_align_bad(bus.Req_we, bus.Req_funct3, bus.Req_addr[1:0])
                 | ((bus.Req_addr >> AW) != 32'd0);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wbuf_q  <= wbuf_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    wbuf_d  = wbuf_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    // Outputs are pure decodes of registered state, so an asynchronous
    // reset clears them (including a Mem_wr_en in flight) immediately.
    bus.Req_ready = 1'b0;
    bus.Rsp_valid = 1'b0;
    bus.Rsp_rdata = '0;
    bus.Rsp_err   = 1'b0;
    Mem_addr      = '0;
    Mem_rd_en     = 1'b0;
    Mem_wr_en     = 1'b0;
    Mem_wdata     = '0;

    case (state_q)
      ST_IDLE: begin
        bus.Req_ready = Rst_n;
        if (bus.Req_valid) begin
          addr_d  = bus.Req_addr;
          f3_d    = bus.Req_funct3;
          we_d    = bus.Req_we;
          wdata_d = bus.Req_wdata;
          rdata_d = '0;             // stores and errors answer with zero
          err_d   = req_err;
          if (req_err)
            state_d = ST_RESP;
          else if (bus.Req_we && bus.Req_funct3 == F3_W)
            state_d = ST_WR;        // full-word store needs no read
          else
            state_d = ST_RD;
        end
      end

      ST_RD: begin
        Mem_addr  = {addr_q[31:2], 2'b00};
        Mem_rd_en = 1'b1;
        state_d   = ST_RDATA;
      end

      ST_RDATA: begin
        Mem_addr = {addr_q[31:2], 2'b00};
        if (we_q) begin
          wbuf_d  = lane_merged;
          state_d = ST_WR;
        end else begin
          rdata_d = lane_load;
          state_d = ST_RESP;
        end
      end

      ST_WR: begin
        Mem_addr  = {addr_q[31:2], 2'b00};
        Mem_wr_en = 1'b1;
        Mem_wdata = (f3_q == F3_W) ? wdata_q : wbuf_q;
        state_d   = ST_RESP;
      end

      ST_RESP: begin
        Mem_addr      = {addr_q[31:2], 2'b00};
        bus.Rsp_valid = 1'b1;
        bus.Rsp_rdata = rdata_q;
        bus.Rsp_err   = err_q;
        state_d       = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
